// File: rtl/pt2262_tx_scheduler_pkg.sv
// pt2262_sched_pkg: scheduler FSM state type and the PT2262 address/data
// widths shared with the encoder and decoder. No ports.
package pt2262_sched_pkg;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 4;
   typedef enum logic [2:0] {IDLE, GRANT, START, WAIT_DONE, GAP, RELEASE} sched_state_t;
endpackage

// File: rtl/pt2262_tx_scheduler_if.sv
// pt2262_tx_scheduler_if: handshake between the scheduler and one PT2262 encoder.
//   enc_A/enc_D     address/data word, held for a whole grant
//   enc_start       1-cycle pulse launching one frame
//   enc_frame_done  1-cycle pulse from the encoder at the end of the sync bit
//   master = scheduler side, slave = encoder side
interface pt2262_tx_scheduler_if
   import pt2262_sched_pkg::*;
;
   logic [ADDR_W-1:0] enc_A;
   logic [DATA_W-1:0] enc_D;
   logic              enc_start;
   logic              enc_frame_done;
   modport master (output enc_A, enc_D, enc_start, input enc_frame_done);
   modport slave  (input enc_A, enc_D, enc_start, output enc_frame_done);
endinterface

// File: rtl/pt2262_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req     request vector
//   ptr     index where the ascending, wrapping search starts
//   winner  one-hot first set request at or after ptr (zero if none)
//   idx     index of winner
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  winner,
   output logic [IW-1:0] idx
);
   logic [IW-1:0] k;
   // Scan from the far end back toward ptr so the last hit is the nearest one.
   always_comb begin
      winner = '0;
      idx = '0;
      k = '0;
      for (int i = N - 1; i >= 0; i--) begin
         k = IW'((int'(ptr) + i) % N);
         if (req[k]) idx = k;
      end
      winner[idx] = |req;
   end
endmodule

// File: rtl/pt2262_tx_scheduler.sv
// pt2262_tx_scheduler: shares one PT2262 encoder between N_REQ requesters,
// sending REPEAT frames per grant separated by GAP_CYCLES idle clocks.
//   clk, reset  3 MHz clock, asynchronous active-high reset
//   req_i       level requests, held until ack_o/err_o
//   addr_i      8-bit address of requester k at [8k+7:8k]
//   data_i      4-bit data of requester k at [4k+3:4k]
//   grant_o     one-hot encoder owner
//   ack_o       1-cycle pulse after all frames completed
//   err_o       1-cycle pulse on encoder timeout or request drop
//   busy_o      high whenever not idle
//   enc         encoder handshake (master side)
module pt2262_tx_scheduler
   import pt2262_sched_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int REPEAT     = 4,
   parameter int GAP_CYCLES = 96,
   parameter int TIMEOUT    = 65535
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req_i,
   input  logic [ADDR_W*N_REQ-1:0]  addr_i,
   input  logic [DATA_W*N_REQ-1:0]  data_i,
   output logic [N_REQ-1:0]         grant_o,
   output logic [N_REQ-1:0]         ack_o,
   output logic [N_REQ-1:0]         err_o,
   output logic                     busy_o,
   pt2262_tx_scheduler_if.master    enc
);
   localparam int IW = $clog2(N_REQ);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   sched_state_t      state, nxt;
   logic [IW-1:0]     rr_ptr, owner, win_idx;
   logic [N_REQ-1:0]  owner_oh, win_oh;
   logic [3:0]        frame_cnt;
   logic [GW-1:0]     gap_cnt;
   logic [TW-1:0]     tmo_cnt;
   logic [ADDR_W-1:0] addr_a [N_REQ];
   logic [DATA_W-1:0] data_a [N_REQ];
   logic              last_frame, tmo_hit, gap_end, fin_ack, fin_err;

   for (genvar g = 0; g < N_REQ; g++) begin : g_split
      assign addr_a[g] = addr_i[ADDR_W*g +: ADDR_W];
      assign data_a[g] = data_i[DATA_W*g +: DATA_W];
   end

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req    (req_i),
      .ptr    (rr_ptr),
      .winner (win_oh),
      .idx    (win_idx)
   );

   // tmo_hit fires on the edge where the count would reach TIMEOUT, so the
   // error pulse appears TIMEOUT+1 clocks after enc_start.
   assign last_frame = frame_cnt + 4'd1 == 4'(REPEAT);
   assign tmo_hit    = tmo_cnt == TW'(TIMEOUT - 1);
   assign gap_end    = gap_cnt == GW'(GAP_CYCLES);
   // A done pulse always beats a simultaneous timeout.
   assign fin_ack    = state == WAIT_DONE && enc.enc_frame_done && last_frame;
   assign fin_err    = (state == WAIT_DONE && !enc.enc_frame_done && tmo_hit) ||
                       (state == GAP && gap_end && !req_i[owner]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:      nxt = |req_i ? GRANT : IDLE;
         GRANT:     nxt = START;
         START:     nxt = WAIT_DONE;
         WAIT_DONE: nxt = enc.enc_frame_done ? (last_frame ? RELEASE : GAP) : (tmo_hit ? RELEASE : WAIT_DONE);
         GAP:       nxt = !gap_end ? GAP : (req_i[owner] ? START : RELEASE);
         RELEASE:   nxt = IDLE;
         default:   nxt = IDLE;
      endcase
   end

   // Outputs are registered from nxt so each one lines up with its state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr        <= '0;
         owner         <= '0;
         owner_oh      <= '0;
         frame_cnt     <= '0;
         gap_cnt       <= '0;
         tmo_cnt       <= '0;
         grant_o       <= '0;
         ack_o         <= '0;
         err_o         <= '0;
         busy_o        <= 1'b0;
         enc.enc_A     <= '0;
         enc.enc_D     <= '0;
         enc.enc_start <= 1'b0;
      end else begin
         if (state == IDLE) begin
            owner    <= win_idx;
            owner_oh <= win_oh;
         end
         if (state == GRANT) begin
            enc.enc_A <= addr_a[owner];
            enc.enc_D <= data_a[owner];
         end
         if (state == RELEASE) rr_ptr <= owner == IW'(N_REQ - 1) ? '0 : owner + 1'b1;
         frame_cnt     <= state == GRANT ? '0 : frame_cnt + 4'(state == WAIT_DONE && enc.enc_frame_done);
         gap_cnt       <= state != GAP ? '0 : gap_cnt + GW'(!gap_end);
         tmo_cnt       <= state != WAIT_DONE ? '0 : tmo_cnt + TW'(!tmo_hit);
         grant_o       <= (nxt == IDLE || nxt == GRANT) ? '0 : owner_oh;
         ack_o         <= fin_ack ? owner_oh : '0;
         err_o         <= fin_err ? owner_oh : '0;
         enc.enc_start <= nxt == START;
         busy_o        <= nxt != IDLE;
      end
   end
endmodule
